// File: rtl/mem_access_ctrl.sv
// Single-word load/store front-end for a clocked block RAM with a valid/ready response channel.
// Optional memory-mapped I/O window above MMIO_BASE is compiled in with `define LSU_MMIO_EN.
module mem_access_ctrl #(
    parameter int                     WIDTH         = 16,
    parameter int                     RAM_ADDR_BITS = 16,
    parameter logic [RAM_ADDR_BITS-1:0] MMIO_BASE   = 16'hFF00
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [RAM_ADDR_BITS-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     mem_en,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic [WIDTH-1:0]         io_in,
    output logic [WIDTH-1:0]         io_out
);

`ifdef LSU_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t                   state_q;
    logic                     we_q;
    logic                     mmio_q;
    logic                     req_ready_q;
    logic                     rsp_valid_q;
    logic [WIDTH-1:0]         rsp_rdata_q;
    logic                     mem_en_q;
    logic                     mem_write_q;
    logic                     mem_read_q;
    logic [RAM_ADDR_BITS-1:0] mem_adr_q;
    logic [WIDTH-1:0]         mem_wdata_q;
    logic [WIDTH-1:0]         io_out_q;
    logic                     mmio_d;

    // Decoded at accept time so the RAM strobes can be registered for the ISSUE cycle.
    assign mmio_d = MMIO && (req_addr >= MMIO_BASE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            mmio_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            io_out_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q     <= ISSUE;
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        mmio_q      <= mmio_d;
                        mem_adr_q   <= req_addr;
                        mem_wdata_q <= req_wdata;
                        mem_en_q    <= ~mmio_d;
                        mem_write_q <= req_we & ~mmio_d;
                        mem_read_q  <= ~req_we & ~mmio_d;
                    end
                end
                ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    if (we_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        if (mmio_q) io_out_q <= mem_wdata_q;
                    end else begin
                        state_q <= CAPTURE;
                        if (mmio_q) rsp_rdata_q <= io_in;
                    end
                end
                CAPTURE: begin
                    // RAM read data is valid in this cycle; I/O loads already hold io_in.
                    if (!mmio_q) rsp_rdata_q <= mem_rdata;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign io_out    = io_out_q;

endmodule
